// File: rtl/front_end_pkg.sv
// Constants and types shared by the front-end request path (scheduler/selector)
// and the read-return reorder buffer.
package front_end_pkg;

    localparam int INDEX_BITS = 7;
    localparam int DATA_BITS  = 16;
    localparam int DEPTH      = 1 << INDEX_BITS;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } req_type_e;

    // Request word layout used by the scheduler/selector path: {index, type}
    localparam int REQ_TYPE_POS  = 0;
    localparam int REQ_INDEX_LSB = 1;
    localparam int REQ_INDEX_MSB = REQ_INDEX_LSB + INDEX_BITS - 1;

    // Distance of a tag from the head, modulo the buffer depth.
    function automatic logic [INDEX_BITS-1:0] idx_dist(
        input logic [INDEX_BITS-1:0] idx,
        input logic [INDEX_BITS-1:0] head
    );
        return idx - head;
    endfunction

endpackage

// File: rtl/rob_mem.sv
// Reorder-buffer data storage: one synchronous write port, one asynchronous
// read port. Contents are not reset.
module rob_mem #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/read_return_rob.sv
// Read-return reorder buffer: tags read requests, collects out-of-order
// responses and releases them in allocation order.
module read_return_rob
    import front_end_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [INDEX_BITS-1:0] req_index,
    input  logic                  rsp_valid,
    input  logic [INDEX_BITS-1:0] rsp_index,
    input  logic [DATA_BITS-1:0]  rsp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INDEX_BITS-1:0] out_index,
    output logic [DATA_BITS-1:0]  out_data,
    output logic [INDEX_BITS:0]   count,
    output logic                  err
);

    localparam logic [INDEX_BITS:0] FULL_COUNT = (INDEX_BITS+1)'(DEPTH);

    logic [INDEX_BITS-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [INDEX_BITS-1:0] ret_ptr_q, ret_ptr_d;
    logic [INDEX_BITS:0]   count_q, count_d;
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic                  err_q, err_d;

    logic alloc;
    logic pop;
    logic rsp_allocated;
    logic fill_ok;

    assign req_ready = (count_q != FULL_COUNT);
    assign req_index = alloc_ptr_q;
    assign out_valid = vld_q[ret_ptr_q];
    assign out_index = ret_ptr_q;
    assign count     = count_q;
    assign err       = err_q;

    assign alloc = req_valid && req_ready;
    assign pop   = out_valid && out_ready;

    // A response to the popping head already has its fill bit set, so it is
    // rejected as a duplicate without any extra term here.
    assign rsp_allocated = {1'b0, idx_dist(rsp_index, ret_ptr_q)} < count_q;
    assign fill_ok       = rsp_valid && rsp_allocated && !vld_q[rsp_index];

    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        ret_ptr_d   = ret_ptr_q;
        count_d     = count_q;
        vld_d       = vld_q;
        err_d       = err_q;

        if (alloc) begin
            alloc_ptr_d = alloc_ptr_q + 1'b1;
        end
        if (pop) begin
            vld_d[ret_ptr_q] = 1'b0;
            ret_ptr_d        = ret_ptr_q + 1'b1;
        end
        if (fill_ok) begin
            vld_d[rsp_index] = 1'b1;
        end

        if (alloc && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !alloc) begin
            count_d = count_q - 1'b1;
        end

        if (rsp_valid && !fill_ok) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr_q <= '0;
            ret_ptr_q   <= '0;
            count_q     <= '0;
            vld_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            ret_ptr_q   <= ret_ptr_d;
            count_q     <= count_d;
            vld_q       <= vld_d;
            err_q       <= err_d;
        end
    end

    rob_mem #(
        .ADDR_BITS (INDEX_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_rob_mem (
        .clk     (clk),
        .wr_en   (fill_ok),
        .wr_addr (rsp_index),
        .wr_data (rsp_data),
        .rd_addr (ret_ptr_q),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_read_return_rob.sv
// Bench for read_return_rob: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the buffer.
module tb_read_return_rob;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_index;
    logic        rsp_valid;
    logic [6:0]  rsp_index;
    logic [15:0] rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_index;
    logic [15:0] out_data;
    logic [7:0]  count;
    logic        err;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 0;

    read_return_rob dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_index (req_index),
        .rsp_valid (rsp_valid),
        .rsp_index (rsp_index),
        .rsp_data  (rsp_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .count     (count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: outstanding tags in allocation order, per-tag fill flag and data.
    int          outq[$];
    bit          mfill[128];
    logic [15:0] mdat[128];
    int          alloc_tag = 0;
    bit          merr = 0;

    function automatic bit in_flight(input int t);
        foreach (outq[i]) if (outq[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        bit head_ok, do_pop, do_fill, can_alloc;
        int t;
        if (rst) begin
            outq.delete();
            foreach (mfill[i]) mfill[i] = 1'b0;
            alloc_tag = 0;
            merr = 1'b0;
        end else begin
            head_ok   = (outq.size() > 0) && mfill[outq[0]];
            do_pop    = head_ok && out_ready;
            can_alloc = outq.size() < 128;
            t         = int'(rsp_index);
            do_fill   = rsp_valid && in_flight(t) && !mfill[t];
            if (rsp_valid && !do_fill) merr = 1'b1;
            if (do_pop) begin
                mfill[outq[0]] = 1'b0;
                void'(outq.pop_front());
            end
            if (do_fill) begin
                mfill[t] = 1'b1;
                mdat[t]  = rsp_data;
            end
            if (req_valid && can_alloc) begin
                outq.push_back(alloc_tag);
                alloc_tag = (alloc_tag + 1) % 128;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit hv;
        int ret_tag;
        if (chk_en) begin
            hv      = (outq.size() > 0) && mfill[outq[0]];
            ret_tag = (((alloc_tag - outq.size()) % 128) + 128) % 128;
            check("req_ready", 32'(req_ready), 32'(outq.size() < 128));
            check("req_index", 32'(req_index), 32'(alloc_tag));
            check("out_valid", 32'(out_valid), 32'(hv));
            check("out_index", 32'(out_index), 32'(ret_tag));
            check("count",     32'(count),     32'(outq.size()));
            check("err",       32'(err),       32'(merr));
            if (hv) check("out_data", 32'(out_data), 32'(mdat[outq[0]]));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        rsp_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int cands[$];
        rst = 1'b1;
        rsp_index = '0;
        rsp_data  = '0;
        idle();
        step();
        step();
        chk_en = 1'b1;
        rst = 1'b0;
        step();

        // Idle after reset
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_req_index", 32'(req_index), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_err",       32'(err),       32'd0);

        // Out-of-order return, in-order release
        req_valid = 1'b1;
        repeat (3) step();
        req_valid = 1'b0;
        check("ooo_count3", 32'(count), 32'd3);
        out_ready = 1'b1;
        rsp_valid = 1'b1; rsp_index = 7'd2; rsp_data = 16'hBEEF;
        step();
        check("ooo_no_head", 32'(out_valid), 32'd0);
        rsp_index = 7'd0; rsp_data = 16'h1111;
        step();
        check("ooo_v0",    32'(out_valid), 32'd1);
        check("ooo_i0",    32'(out_index), 32'd0);
        check("ooo_d0",    32'(out_data),  32'h1111);
        rsp_index = 7'd1; rsp_data = 16'h2222;
        step();
        check("ooo_i1",    32'(out_index), 32'd1);
        check("ooo_d1",    32'(out_data),  32'h2222);
        rsp_valid = 1'b0;
        step();
        check("ooo_i2",    32'(out_index), 32'd2);
        check("ooo_d2",    32'(out_data),  32'hBEEF);
        step();
        check("ooo_count0", 32'(count),    32'd0);
        check("ooo_empty",  32'(out_valid), 32'd0);

        // Full buffer and wrap-around
        do_reset();
        req_valid = 1'b1;
        repeat (128) step();
        check("full_ready", 32'(req_ready), 32'd0);
        check("full_count", 32'(count),     32'd128);
        step();
        check("full_hold",  32'(count),     32'd128);
        req_valid = 1'b0;
        rsp_valid = 1'b1; rsp_index = 7'd0; rsp_data = 16'h0F0F;
        step();
        rsp_valid = 1'b0;
        check("full_head",   32'(out_valid), 32'd1);
        check("full_popcyc", 32'(req_ready), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("full_after_pop", 32'(req_ready), 32'd1);
        check("full_wrap_idx",  32'(req_index), 32'd0);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("full_refill", 32'(count),     32'd128);
        check("full_next",   32'(req_index), 32'd1);

        // Duplicate response
        do_reset();
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        rsp_valid = 1'b1; rsp_index = 7'd0; rsp_data = 16'hAAAA;
        step();
        check("dup_first_err", 32'(err), 32'd0);
        rsp_data = 16'h5555;
        step();
        rsp_valid = 1'b0;
        check("dup_err",  32'(err),      32'd1);
        check("dup_data", 32'(out_data), 32'hAAAA);

        // Response while empty
        do_reset();
        step();
        rsp_valid = 1'b1; rsp_index = 7'd5; rsp_data = 16'h1357;
        step();
        rsp_valid = 1'b0;
        check("empty_err",   32'(err),       32'd1);
        check("empty_count", 32'(count),     32'd0);
        check("empty_valid", 32'(out_valid), 32'd0);

        // Stall, simultaneous events, reset with entries outstanding
        do_reset();
        req_valid = 1'b1;
        repeat (3) step();
        req_valid = 1'b0;
        rsp_valid = 1'b1; rsp_index = 7'd0; rsp_data = 16'h1234;
        step();
        rsp_valid = 1'b0;
        repeat (5) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data",  32'(out_data),  32'h1234);
            step();
        end
        out_ready = 1'b1; req_valid = 1'b1;
        rsp_valid = 1'b1; rsp_index = 7'd1; rsp_data = 16'h5678;
        step();
        idle();
        check("sim_count", 32'(count),     32'd3);
        check("sim_head",  32'(out_index), 32'd1);
        check("sim_data",  32'(out_data),  32'h5678);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_index", 32'(req_index), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_head",  32'(out_index), 32'd0);
        check("mid_rst_count", 32'(count),     32'd0);
        check("mid_rst_err",   32'(err),       32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 699) == 0);
            req_valid = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            rsp_valid = 1'b0;
            rsp_data  = 16'($urandom);
            cands.delete();
            foreach (outq[i]) if (!mfill[outq[i]]) cands.push_back(outq[i]);
            if ($urandom_range(0, 99) < 3) begin
                rsp_valid = 1'b1;
                rsp_index = 7'($urandom_range(0, 127));
            end else if (cands.size() > 0 && $urandom_range(0, 99) < 55) begin
                rsp_valid = 1'b1;
                rsp_index = 7'(cands[$urandom_range(0, cands.size() - 1)]);
            end
            step();
        end

        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
